// File: rtl/median_window_gen.sv
// 3x3 window generator: two line buffers feed a shifting 3x3 register window that is paced for a 4-cycle median filter.
// Optional WIN_CNT_EN adds a per-frame window counter output (win_cnt).
module median_window_gen #(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int DW      = 16,
  parameter int WIN_GAP = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_vld,
  input  logic          pix_sof,
  input  logic [DW-1:0] pix_data,
  output logic          pix_rdy,
  output logic          win_gen_flag,
  output logic [DW-1:0] data_out0,
  output logic [DW-1:0] data_out1,
  output logic [DW-1:0] data_out2,
  output logic [DW-1:0] data_out3,
  output logic [DW-1:0] data_out4,
  output logic [DW-1:0] data_out5,
  output logic [DW-1:0] data_out6,
  output logic [DW-1:0] data_out7,
  output logic [DW-1:0] data_out8,
`ifdef WIN_CNT_EN
  output logic [31:0]   win_cnt,
`endif
  output logic          frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int GW = $clog2(WIN_GAP + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(WIN_GAP);

  logic [CW-1:0] col_cnt, col_eff;
  logic [RW-1:0] row_cnt, row_eff;
  logic [GW-1:0] gap_cnt;
  logic [DW-1:0] lb0 [IMG_W];
  logic [DW-1:0] lb1 [IMG_W];
  logic [2:0][2:0][DW-1:0] win;     // [row][col], row 0 = oldest line
  logic [2:0][DW-1:0]      new_col; // [row]
  logic accept, at_win, at_last;

  assign pix_rdy = (gap_cnt == '0);
  assign accept  = pix_vld & pix_rdy;
  // sof forces the pixel to (0,0) whatever the counters say
  assign col_eff = pix_sof ? '0 : col_cnt;
  assign row_eff = pix_sof ? '0 : row_cnt;
  assign at_win  = (row_eff >= RW'(2)) && (col_eff >= CW'(2));
  assign at_last = (row_eff == ROW_LAST) && (col_eff == COL_LAST);

  assign new_col[0] = lb1[col_eff];
  assign new_col[1] = lb0[col_eff];
  assign new_col[2] = pix_data;

  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col_eff] <= lb0[col_eff];
      lb0[col_eff] <= pix_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt      <= '0;
      row_cnt      <= '0;
      gap_cnt      <= '0;
      win          <= '0;
      win_gen_flag <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      win_gen_flag <= accept & at_win;
      frame_done   <= accept & at_last;
      if (accept & at_win)     gap_cnt <= GAP_LOAD;
      else if (gap_cnt != '0)  gap_cnt <= gap_cnt - GW'(1);
      if (accept) begin
        for (int r = 0; r < 3; r++) win[r] <= {new_col[r], win[r][2], win[r][1]};
        if (col_eff == COL_LAST) begin
          col_cnt <= '0;
          row_cnt <= (row_eff == ROW_LAST) ? '0 : row_eff + RW'(1);
        end else begin
          col_cnt <= col_eff + CW'(1);
          row_cnt <= row_eff;
        end
      end
    end
  end

`ifdef WIN_CNT_EN
  // counts at the accept so the value steps together with win_gen_flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     win_cnt <= '0;
    else if (accept & pix_sof)   win_cnt <= '0;
    else if (accept & at_win)    win_cnt <= win_cnt + 32'd1;
  end
`endif

  assign data_out0 = win[0][0];
  assign data_out1 = win[0][1];
  assign data_out2 = win[0][2];
  assign data_out3 = win[1][0];
  assign data_out4 = win[1][1];
  assign data_out5 = win[1][2];
  assign data_out6 = win[2][0];
  assign data_out7 = win[2][1];
  assign data_out8 = win[2][2];
endmodule

// File: tb/tb_median_window_gen.sv
// Self-checking bench for median_window_gen on a 5x4 image against a frame-array reference model.
module tb_median_window_gen;
  localparam int W = 5, H = 4, DW = 16, GAP = 4;

  logic clk = 1'b0, rst = 1'b1, pix_vld = 1'b0, pix_sof = 1'b0;
  logic [DW-1:0] pix_data = '0;
  logic pix_rdy, win_gen_flag, frame_done;
  logic [DW-1:0] d0, d1, d2, d3, d4, d5, d6, d7, d8;
`ifdef WIN_CNT_EN
  logic [31:0] win_cnt;
`endif
  wire [9*DW-1:0] dout_all = {d0, d1, d2, d3, d4, d5, d6, d7, d8};

  median_window_gen #(.IMG_W(W), .IMG_H(H), .DW(DW), .WIN_GAP(GAP)) dut (
    .clk(clk), .rst(rst), .pix_vld(pix_vld), .pix_sof(pix_sof), .pix_data(pix_data),
    .pix_rdy(pix_rdy), .win_gen_flag(win_gen_flag),
    .data_out0(d0), .data_out1(d1), .data_out2(d2), .data_out3(d3), .data_out4(d4),
    .data_out5(d5), .data_out6(d6), .data_out7(d7), .data_out8(d8),
`ifdef WIN_CNT_EN
    .win_cnt(win_cnt),
`endif
    .frame_done(frame_done));

  always #5 clk = ~clk;

  // reference model: the frame as a 2D array, window read straight out of it
  int mrow, mcol, cyc, last_win;
  logic [DW-1:0] img [H][W];
  bit exp_flag, exp_done, exp_rdy;
  logic [9*DW-1:0] exp_win;
  int n_chk, n_fail, n_flag, n_done;

  task automatic model_reset();
    mrow = 0; mcol = 0; last_win = -1000;
  endtask

  task automatic model_step(input bit acc, input bit sof, input logic [DW-1:0] d);
    exp_flag = 1'b0; exp_done = 1'b0;
    if (acc) begin
      if (sof) begin mrow = 0; mcol = 0; end
      img[mrow][mcol] = d;
      if (mrow >= 2 && mcol >= 2) begin
        exp_flag = 1'b1;
        last_win = cyc;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            exp_win[(8 - (r*3 + c))*DW +: DW] = img[mrow-2+r][mcol-2+c];
      end
      exp_done = (mrow == H-1 && mcol == W-1);
      mcol++;
      if (mcol == W) begin mcol = 0; mrow = (mrow + 1) % H; end
    end
    cyc++;
    exp_rdy = !((cyc - last_win) >= 1 && (cyc - last_win) <= GAP);
  endtask

  // one clock: drive at negedge, let the edge pass, return at the next negedge
  task automatic drive(input bit v, input bit s, input logic [DW-1:0] d, output bit acc);
    pix_vld = v; pix_sof = s; pix_data = d;
    acc = v && (pix_rdy === 1'b1);
    @(posedge clk); @(negedge clk);
    model_step(acc, s, d);
    if (win_gen_flag === 1'b1) n_flag++;
    if (frame_done === 1'b1) n_done++;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, acc);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_chk += 4;
    if (win_gen_flag !== 1'b0) begin n_fail++; $display("FAIL reset_flag got=%b exp=0", win_gen_flag); end
    if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", frame_done); end
    if (dout_all !== '0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", dout_all); end
    if (pix_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy got=%b exp=1", pix_rdy); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if (pix_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_release_rdy got=%b exp=1", pix_rdy); end
`ifdef WIN_CNT_EN
    n_chk++;
    if (win_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_win_cnt got=%0d exp=0", win_cnt); end
`endif
  endtask

  task automatic test_frame_pattern();
    int idx = 0, cycles = 0;
    bit acc, first_seen = 1'b0;
    n_flag = 0; n_done = 0;
    while (idx < W*H && cycles < 300) begin
      drive(1'b1, idx == 0, DW'((idx / W) * 16 + idx % W), acc);
      if (acc) idx++;
      cycles++;
      n_chk += 3;
      if (pix_rdy !== exp_rdy) begin n_fail++; $display("FAIL pattern_rdy cyc=%0d got=%b exp=%b", cyc, pix_rdy, exp_rdy); end
      if (win_gen_flag !== exp_flag) begin n_fail++; $display("FAIL pattern_flag cyc=%0d got=%b exp=%b", cyc, win_gen_flag, exp_flag); end
      if (frame_done !== exp_done) begin n_fail++; $display("FAIL pattern_done cyc=%0d got=%b exp=%b", cyc, frame_done, exp_done); end
      if (exp_flag) begin
        n_chk++;
        if (dout_all !== exp_win) begin n_fail++; $display("FAIL pattern_win cyc=%0d got=%h exp=%h", cyc, dout_all, exp_win); end
      end
      if (win_gen_flag === 1'b1 && !first_seen) begin
        first_seen = 1'b1;
        n_chk++;
        if ({d0, d4, d8} !== {16'h00, 16'h11, 16'h22}) begin
          n_fail++; $display("FAIL first_window got=%h/%h/%h exp=0000/0011/0022", d0, d4, d8);
        end
      end
      if (frame_done === 1'b1) begin
        n_chk++;
        if (win_gen_flag !== 1'b1 || d8 !== 16'h34) begin
          n_fail++; $display("FAIL last_window flag=%b d8=%h exp flag=1 d8=0034", win_gen_flag, d8);
        end
`ifdef WIN_CNT_EN
        n_chk++;
        if (win_cnt !== 32'd6) begin n_fail++; $display("FAIL win_cnt_final got=%0d exp=6", win_cnt); end
`endif
      end
    end
    n_chk += 3;
    if (idx != W*H) begin n_fail++; $display("FAIL pattern_timeout accepted=%0d exp=%0d", idx, W*H); end
    if (n_flag != 6) begin n_fail++; $display("FAIL pattern_flag_count got=%0d exp=6", n_flag); end
    if (n_done != 1) begin n_fail++; $display("FAIL pattern_done_count got=%0d exp=1", n_done); end
    idle(GAP + 2);
`ifdef WIN_CNT_EN
    n_chk++;
    if (win_cnt !== 32'd6) begin n_fail++; $display("FAIL win_cnt_hold got=%0d exp=6", win_cnt); end
`endif
  endtask

  task automatic test_random_gaps();
    int idx = 0, cycles = 0;
    bit acc, v;
    logic [DW-1:0] px;
    n_flag = 0; n_done = 0;
    px = DW'($urandom);
    while (idx < 2*W*H && cycles < 1000) begin
      v = ($urandom_range(0, 2) != 0);
      drive(v, (idx % (W*H)) == 0, px, acc);
      if (acc) begin
`ifdef WIN_CNT_EN
        if (idx % (W*H) == 0) begin
          n_chk++;
          if (win_cnt !== 32'd0) begin n_fail++; $display("FAIL win_cnt_sof_clear got=%0d exp=0", win_cnt); end
        end
`endif
        idx++;
        px = DW'($urandom);
      end
      cycles++;
      n_chk += 3;
      if (pix_rdy !== exp_rdy) begin n_fail++; $display("FAIL random_rdy cyc=%0d got=%b exp=%b", cyc, pix_rdy, exp_rdy); end
      if (win_gen_flag !== exp_flag) begin n_fail++; $display("FAIL random_flag cyc=%0d got=%b exp=%b", cyc, win_gen_flag, exp_flag); end
      if (frame_done !== exp_done) begin n_fail++; $display("FAIL random_done cyc=%0d got=%b exp=%b", cyc, frame_done, exp_done); end
      if (exp_flag) begin
        n_chk++;
        if (dout_all !== exp_win) begin n_fail++; $display("FAIL random_win cyc=%0d got=%h exp=%h", cyc, dout_all, exp_win); end
      end
    end
    n_chk += 3;
    if (idx != 2*W*H) begin n_fail++; $display("FAIL random_timeout accepted=%0d exp=%0d", idx, 2*W*H); end
    if (n_flag != 12) begin n_fail++; $display("FAIL random_flag_count got=%0d exp=12", n_flag); end
    if (n_done != 2) begin n_fail++; $display("FAIL random_done_count got=%0d exp=2", n_done); end
    idle(GAP + 2);
  endtask

  task automatic test_mid_sof();
    int idx = 0, cycles = 0;
    bit acc, sof, first_new = 1'b0;
    logic [DW-1:0] px;
    n_flag = 0; n_done = 0;
    // 13 pixels of an old frame up to (2,2), then a new frame whose first pixel lands at (2,3)
    while (idx < 13 + W*H && cycles < 400) begin
      sof = (idx == 0) || (idx == 13);
      if (idx < 13) px = DW'((idx / W) * 16 + idx % W);
      else          px = DW'(16'h100 + ((idx - 13) / W) * 16 + (idx - 13) % W);
      drive(1'b1, sof, px, acc);
      if (acc) idx++;
      cycles++;
      n_chk += 3;
      if (pix_rdy !== exp_rdy) begin n_fail++; $display("FAIL sof_rdy cyc=%0d got=%b exp=%b", cyc, pix_rdy, exp_rdy); end
      if (win_gen_flag !== exp_flag) begin n_fail++; $display("FAIL sof_flag cyc=%0d got=%b exp=%b", cyc, win_gen_flag, exp_flag); end
      if (frame_done !== exp_done) begin n_fail++; $display("FAIL sof_done cyc=%0d got=%b exp=%b", cyc, frame_done, exp_done); end
      if (exp_flag) begin
        n_chk++;
        if (dout_all !== exp_win) begin n_fail++; $display("FAIL sof_win cyc=%0d got=%h exp=%h", cyc, dout_all, exp_win); end
      end
      if (win_gen_flag === 1'b1 && idx > 13 && !first_new) begin
        first_new = 1'b1;
        n_chk++;
        if ({d0, d8} !== {16'h100, 16'h122}) begin
          n_fail++; $display("FAIL sof_first_new got=%h/%h exp=0100/0122", d0, d8);
        end
      end
    end
    n_chk += 3;
    if (idx != 13 + W*H) begin n_fail++; $display("FAIL sof_timeout accepted=%0d exp=%0d", idx, 13 + W*H); end
    if (n_flag != 7) begin n_fail++; $display("FAIL sof_flag_count got=%0d exp=7", n_flag); end
    if (n_done != 1) begin n_fail++; $display("FAIL sof_done_count got=%0d exp=1", n_done); end
    idle(GAP + 2);
  endtask

  task automatic test_reset_mid();
    int idx = 0, cycles = 0;
    bit acc;
    while (idx < 13 && cycles < 100) begin
      drive(1'b1, idx == 0, DW'(16'h300 + idx), acc);
      if (acc) idx++;
      cycles++;
    end
    // the (2,2) window is live here: flag high, data nonzero, rdy low
    rst = 1'b1;
    #1;
    n_chk += 4;
    if (win_gen_flag !== 1'b0) begin n_fail++; $display("FAIL midrst_flag got=%b exp=0", win_gen_flag); end
    if (frame_done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got=%b exp=0", frame_done); end
    if (dout_all !== '0) begin n_fail++; $display("FAIL midrst_data got=%h exp=0", dout_all); end
    if (pix_rdy !== 1'b1) begin n_fail++; $display("FAIL midrst_rdy got=%b exp=1", pix_rdy); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    exp_rdy = 1'b1;
    n_flag = 0; n_done = 0; idx = 0; cycles = 0;
    while (idx < W*H && cycles < 300) begin
      drive(1'b1, 1'b0, DW'($urandom), acc);
      if (acc) idx++;
      cycles++;
      n_chk += 3;
      if (pix_rdy !== exp_rdy) begin n_fail++; $display("FAIL rstframe_rdy cyc=%0d got=%b exp=%b", cyc, pix_rdy, exp_rdy); end
      if (win_gen_flag !== exp_flag) begin n_fail++; $display("FAIL rstframe_flag cyc=%0d got=%b exp=%b", cyc, win_gen_flag, exp_flag); end
      if (frame_done !== exp_done) begin n_fail++; $display("FAIL rstframe_done cyc=%0d got=%b exp=%b", cyc, frame_done, exp_done); end
      if (exp_flag) begin
        n_chk++;
        if (dout_all !== exp_win) begin n_fail++; $display("FAIL rstframe_win cyc=%0d got=%h exp=%h", cyc, dout_all, exp_win); end
      end
    end
    n_chk += 3;
    if (idx != W*H) begin n_fail++; $display("FAIL rstframe_timeout accepted=%0d exp=%0d", idx, W*H); end
    if (n_flag != 6) begin n_fail++; $display("FAIL rstframe_flag_count got=%0d exp=6", n_flag); end
    if (n_done != 1) begin n_fail++; $display("FAIL rstframe_done_count got=%0d exp=1", n_done); end
    idle(GAP + 2);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0;
    model_reset();
    test_reset();
    test_frame_pattern();
    test_random_gaps();
    test_mid_sof();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end
endmodule
